// File: rtl/clk_freq_mon.sv
// Reference-clock frequency monitor: counts mclk cycles over win+1 ref_clk periods and flags out-of-range or dead references.
// Optional glitch filter on the synchronized reference enabled by defining CLKMON_GLITCH_FILT_EN.
module clk_freq_mon #(
  parameter int CW       = 16,
  parameter int SYNC_STG = 2
) (
  input  logic          mclk,
  input  logic          srstz,
  input  logic          ref_clk,
  input  logic          en,
  input  logic [3:0]    win,
  input  logic [CW-1:0] lo_lim,
  input  logic [CW-1:0] hi_lim,
  input  logic          fault_clr,
  output logic [CW-1:0] cnt_out,
  output logic          cnt_vld,
  output logic          fault,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t              state_q, state_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [CW-1:0]       cnt_out_q, cnt_out_d;
  logic                cnt_vld_q, cnt_vld_d;
  logic                fault_q, fault_d;

  logic                ref_s;
  logic                ref_lvl;
  logic                ref_rise;
  logic                cnt_sat;
  logic [CW-1:0]       cnt_inc;

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], ref_clk};
  end

  assign ref_s = sync_q[SYNC_STG-1];

`ifdef CLKMON_GLITCH_FILT_EN
  logic       filt_q, filt_d;
  logic [1:0] run_q, run_d;

  // Output flips on the third consecutive sample that disagrees with it.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (ref_s != filt_q) begin
      if (run_q == 2'd2) begin
        filt_d = ref_s;
      end else begin
        run_d = run_q + 2'd1;
      end
    end
  end

  always_ff @(posedge mclk or negedge srstz) begin
    if (!srstz) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign ref_lvl = filt_q;
`else
  assign ref_lvl = ref_s;
`endif

  always_comb begin
    prev_d = ref_lvl;
  end

  assign ref_rise = ref_lvl & ~prev_q;
  assign cnt_sat  = &cnt_q;
  assign cnt_inc  = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    cnt_out_d = cnt_out_q;
    cnt_vld_d = 1'b0;
    fault_d   = fault_q & ~fault_clr;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) state_d = S_ARM;
      end

      // Counter also runs while waiting so a dead reference is still caught.
      S_ARM: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (ref_rise) begin
          state_d = S_MEAS;
          cnt_d   = '0;
          wcnt_d  = win;
        end else if (cnt_sat) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_MEAS: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if ((ref_rise && (wcnt_q == 4'd0)) || cnt_sat) begin
            state_d = S_DONE;
          end else if (ref_rise) begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end

      // The DONE cycle is already the first cycle of the next window, hence restart at 1.
      S_DONE: begin
        cnt_out_d = cnt_q;
        cnt_vld_d = 1'b1;
        if ((cnt_q < lo_lim) || (cnt_q > hi_lim) || cnt_sat) fault_d = 1'b1;
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_sat) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end else begin
          state_d = S_MEAS;
          cnt_d   = CNT_ONE;
          wcnt_d  = win;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge srstz) begin
    if (!srstz) begin
      state_q   <= S_IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      cnt_out_q <= '0;
      cnt_vld_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      cnt_out_q <= cnt_out_d;
      cnt_vld_q <= cnt_vld_d;
      fault_q   <= fault_d;
    end
  end

  assign cnt_out = cnt_out_q;
  assign cnt_vld = cnt_vld_q;
  assign fault   = fault_q;
  assign busy    = (state_q == S_ARM) || (state_q == S_MEAS);

endmodule

// File: tb/tb_clk_freq_mon.sv
// Scoreboard bench for clk_freq_mon: a 16-bit instance on a 120-cycle reference and an 8-bit instance on a dead reference.
module tb_clk_freq_mon;

  localparam int P = 120;

  typedef struct packed {
    logic [15:0] cnt;
    logic        flt;
  } exp_t;

  logic        mclk = 1'b0;
  logic        srstz;
  logic        ref_clk;
  logic        en;
  logic [3:0]  win;
  logic [15:0] lo_lim, hi_lim;
  logic        fault_clr;
  logic [15:0] cnt_out;
  logic        cnt_vld, fault, busy;

  logic        ref_b, en_b, fault_clr_b;
  logic [3:0]  win_b;
  logic [7:0]  lo_b, hi_b;
  logic [7:0]  cnt_out_b;
  logic        cnt_vld_b, fault_b, busy_b;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   ref_phase = 0;
  int   glitch_left = 0;
  logic glitch_arm = 1'b0;

  always #5 mclk = ~mclk;

  clk_freq_mon #(.CW(16), .SYNC_STG(2)) u_dut_a (
    .mclk(mclk), .srstz(srstz), .ref_clk(ref_clk), .en(en), .win(win),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .fault_clr(fault_clr),
    .cnt_out(cnt_out), .cnt_vld(cnt_vld), .fault(fault), .busy(busy)
  );

  clk_freq_mon #(.CW(8), .SYNC_STG(2)) u_dut_b (
    .mclk(mclk), .srstz(srstz), .ref_clk(ref_b), .en(en_b), .win(win_b),
    .lo_lim(lo_b), .hi_lim(hi_b), .fault_clr(fault_clr_b),
    .cnt_out(cnt_out_b), .cnt_vld(cnt_vld_b), .fault(fault_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
    #1;
  endtask

  task automatic wait_qa(input int target, input int budget, input string name);
    int n = 0;
    while (qa.size() > target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, qa.size(), target);
  endtask

  task automatic wait_qb(input int target, input int budget, input string name);
    int n = 0;
    while (qb.size() > target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, qb.size(), target);
  endtask

  task automatic push_a(input logic [15:0] c, input logic f);
    exp_t e;
    e.cnt = c;
    e.flt = f;
    qa.push_back(e);
  endtask

  // Reference: rises at phase 0, high for P/2; optional one-shot 2-cycle glitch at phase 90.
  initial begin
    ref_clk = 1'b0;
    forever begin
      @(negedge mclk);
      if (glitch_arm && ref_phase == 90) begin
        glitch_left = 2;
        glitch_arm  = 1'b0;
      end
      ref_clk = (ref_phase < P / 2) || (glitch_left > 0);
      if (glitch_left > 0) glitch_left--;
      ref_phase = (ref_phase + 1) % P;
    end
  end

  // Monitors.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      if (srstz === 1'b1 && cnt_vld === 1'b1) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld_a: got cnt_out=%0d expected no pulse", cnt_out);
        end else begin
          e = qa.pop_front();
          check("cnt_out_a", cnt_out, e.cnt);
          check("fault_a", fault, e.flt);
        end
      end
      if (srstz === 1'b1 && cnt_vld_b === 1'b1) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld_b: got cnt_out=%0d expected no pulse", cnt_out_b);
        end else begin
          e = qb.pop_front();
          check("cnt_out_b", cnt_out_b, e.cnt);
          check("fault_b", fault_b, e.flt);
          check("busy_b_rearm", busy_b, 1);
        end
      end
    end
  end

  initial begin
    exp_t eb;
    int   n;
    srstz = 1'b0; en = 1'b0; win = 4'd0; lo_lim = 16'd100; hi_lim = 16'd140; fault_clr = 1'b0;
    ref_b = 1'b0; en_b = 1'b0; win_b = 4'd0; lo_b = 8'd0; hi_b = 8'd255; fault_clr_b = 1'b0;

    tick(3);
    check("rst_cnt_out", cnt_out, 0);
    check("rst_cnt_vld", cnt_vld, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt_out_b", cnt_out_b, 0);
    check("rst_busy_b", busy_b, 0);
    srstz = 1'b1;
    tick(2);

    // Continuous 120-cycle windows.
    repeat (3) push_a(16'd120, 1'b0);
    en = 1'b1;
    tick(1);
    check("busy_arm", busy, 1);
    wait_qa(0, 700, "timeout_win0");
    check("busy_meas", busy, 1);

    // Drop en mid-window: idle, no publish, result retained.
    en = 1'b0;
    tick(1);
    check("busy_after_en_drop", busy, 0);
    check("cnt_out_kept", cnt_out, 120);
    check("vld_after_en_drop", cnt_vld, 0);
    tick(300);
    repeat (2) push_a(16'd120, 1'b0);
    en = 1'b1;
    wait_qa(0, 600, "timeout_reenable");

    // Four-period window above hi_lim; clear, then clear held across the next set.
    en = 1'b0; win = 4'd3; lo_lim = 16'd400; hi_lim = 16'd470;
    tick(2);
    push_a(16'd480, 1'b1);
    push_a(16'd480, 1'b1);
    en = 1'b1;
    wait_qa(1, 1300, "timeout_win3_first");
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_cleared", fault, 0);
    fault_clr = 1'b1;
    wait_qa(0, 800, "timeout_win3_second");
    fault_clr = 1'b0;

    // Asynchronous reset mid-measurement.
    tick(20);
    srstz = 1'b0;
    #1;
    check("mid_rst_cnt_out", cnt_out, 0);
    check("mid_rst_cnt_vld", cnt_vld, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_busy", busy, 0);
    n = 0;
    while (ref_phase != 70 && n < 300) begin
      tick(1);
      n++;
    end
    srstz = 1'b1;
    push_a(16'd480, 1'b1);
    wait_qa(0, 1300, "timeout_after_rst");
    en = 1'b0;

    // Dead reference on the 8-bit instance.
    eb.cnt = 16'd255;
    eb.flt = 1'b1;
    qb.push_back(eb);
    qb.push_back(eb);
    en_b = 1'b1;
    wait_qb(0, 800, "timeout_dead_ref");
    en_b = 1'b0;

    // Single 2-cycle glitch inside one reference period.
    win = 4'd0; lo_lim = 16'd100; hi_lim = 16'd140;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_clr_idle", fault, 0);
`ifdef CLKMON_GLITCH_FILT_EN
    repeat (4) push_a(16'd120, 1'b0);
`else
    push_a(16'd120, 1'b0);
    push_a(16'd90, 1'b1);
    push_a(16'd30, 1'b1);
    push_a(16'd120, 1'b1);
`endif
    en = 1'b1;
    wait_qa(3, 600, "timeout_pre_glitch");
    glitch_arm = 1'b1;
    wait_qa(0, 800, "timeout_glitch");
    en = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_freq_mon.md
CLK_FREQ_MON -- requirements
Module: clk_freq_mon

Interface
REQ-001 CW, 16, width of measurement counter and limit registers.
REQ-002 SYNC_STG, 2, synchronizer flop stages on ref_clk (legal 2..3).
REQ-003 mclk  input  1  system clock; all logic on posedge mclk.
REQ-004 srstz  input  1  reset, asynchronous, active-low.
REQ-005 ref_clk  input  1  slow reference clock, asynchronous to mclk, e.g. a divided 500 Hz clock.
REQ-006 en  input  1  level; 1 = measure continuously, 0 = idle.
REQ-007 win  input  4  window length = win+1 ref_clk periods (1..16); sampled at window start.
REQ-008 lo_lim  input  CW  minimum legal count, inclusive.
REQ-009 hi_lim  input  CW  maximum legal count, inclusive.
REQ-010 fault_clr  input  1  one-cycle pulse; clears fault.
REQ-011 cnt_out  output  CW  last completed count.
REQ-012 cnt_vld  output  1  one-cycle pulse: cnt_out updated.
REQ-013 fault  output  1  sticky out-of-range / dead-reference flag.
REQ-014 busy  output  1  1 in ARM or MEAS state.

Function
REQ-015 ref_clk SHALL pass through a SYNC_STG-flop synchronizer, then a rising-edge detector giving one-cycle pulse ref_rise.
REQ-016 FSM states SHALL be IDLE, ARM, MEAS, DONE; encoding is free.
REQ-017 IDLE->ARM when en=1; counter held at 0.
REQ-018 ARM->MEAS on ref_rise; counter cleared to 0 that cycle; window down-counter loaded with win.
REQ-019 MEAS: counter SHALL increment by 1 each mclk cycle, saturating at all-ones; each ref_rise with window down-counter 0 -> DONE, otherwise decrement it.
REQ-020 Count semantics: cycles from the one after the start ref_rise through the end ref_rise inclusive; ref period P cycles -> count = P*(win+1).
REQ-021 DONE (one cycle): cnt_out <= count, cnt_vld=1, compare; then MEAS if en=1 (end edge starts next window, counter restarts at 1 on first MEAS cycle, window reloaded), else IDLE.
REQ-022 Compare: fault set if count<lo_lim, count>hi_lim, or count saturated; limits unsigned.
REQ-023 Dead reference: counter saturating in ARM or MEAS SHALL go to DONE with cnt_out=all-ones, fault=1, then ARM (if en=1).
REQ-024 fault sticky; cleared by fault_clr; set and fault_clr in same cycle -> fault stays 1.
REQ-025 en=0 in ARM/MEAS: IDLE next cycle, counter cleared, no cnt_vld, cnt_out and fault unchanged.
REQ-026 en=0 in DONE: that result SHALL still be published, then IDLE.
REQ-027 lo_lim>hi_lim: every completed window faults; no special handling.
REQ-028 busy=1 exactly in ARM and MEAS.

Reset
REQ-029 srstz=0 SHALL asynchronously force: FSM IDLE, synchronizer and edge-detect flops 0, counters 0, cnt_out=0, cnt_vld=0, fault=0, busy=0.
REQ-030 Reset mid-measurement SHALL discard the partial count; after release, a new measurement needs a fresh ARM edge.

Configuration
REQ-031 Macro CLKMON_GLITCH_FILT_EN defined: synchronized ref SHALL feed a filter whose output changes only after 3 consecutive equal samples; edge detect uses filter output; pulses shorter than 3 mclk cycles ignored; filter flops reset to 0.
REQ-032 Macro undefined: edge detect uses synchronizer output directly; no filter flops present.
REQ-033 Count values per REQ-020 SHALL be identical in both builds, for clean ref_clk.

Verification
REQ-034 ref period 120 cycles, win=0, lo=100, hi=140, en=1 -> cnt_vld every 120 cycles after first window, cnt_out=120, fault=0.
REQ-035 ref period 120, win=3, lo=400, hi=470 -> cnt_out=480, fault=1; fault_clr pulse -> fault=0; next window refaults.
REQ-036 ref_clk held 0, CW=8 -> after ARM, saturation at 255 -> cnt_out=255, cnt_vld pulse, fault=1, FSM back to ARM.
REQ-037 en dropped mid-MEAS -> IDLE next cycle, busy=0, no cnt_vld, cnt_out keeps prior 120; re-enable -> correct 120 after ARM.
REQ-038 srstz pulsed mid-MEAS -> all outputs 0 immediately; fault_clr coincident with new fault -> fault=1.
REQ-039 With CLKMON_GLITCH_FILT_EN: 2-cycle high glitch inside 120-cycle ref period -> cnt_out stays 120; without macro -> glitch counted as edge, short count and fault.
